dds_multichan_gen: RTL and testbench

- Multi-channel direct-digital-synthesis waveform generator. It is the parametrised next generation of the counter + sine-ROM signal generator.
- A wide phase accumulator feeds N_CH channels. Each channel applies its own phase offset into a shared sine table, or into arithmetic square/sawtooth/triangle generators.
- Adds free-run and counted-burst operation, a valid strobe, and a fixed pipeline latency.
- Sits between the control registers (incr, offsets, mode) and the DAC/scope outputs of the lab top level.

---
 rtl/dds_multichan_gen.sv | 180 ++++++++++++++++++
 tb/tb_dds_multichan_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_multichan_gen.sv
// Multi-channel DDS generator: shared phase accumulator, per-channel phase offset,
// sine/square/sawtooth/triangle output, free-run or counted burst, fixed 2-cycle latency.
module dds_multichan_gen #(
  parameter int PHASE_W = 16,
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8,
  parameter int N_CH    = 2,
  parameter int BURST_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      start,
  input  logic                      stop,
  input  logic [BURST_W-1:0]        burst_len,
  input  logic [1:0]                mode,
  input  logic [PHASE_W-1:0]        incr,
  input  logic [N_CH*A_WIDTH-1:0]   offset,
  output logic                      busy,
  output logic                      dvalid,
  output logic [N_CH*D_WIDTH-1:0]   dout
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BURST = 2'd2} state_t;

  localparam int DEPTH = 1 << A_WIDTH;

  // Sine table entry built at elaboration: quarter-wave reduction, then a Q28 Taylor series.
  function automatic logic [D_WIDTH-1:0] sine_entry(input int idx);
    longint pi_q, x, x2, term, sum, amp, mag, res;
    int     q_len, quad, j;
    q_len = DEPTH / 4;
    quad  = idx / q_len;
    j     = idx % q_len;
    if (quad == 1 || quad == 3) j = q_len - j;
    pi_q = 64'sd843314857;
    x    = (pi_q * longint'(j)) / (64'sd2 * longint'(q_len));
    x2   = (x * x) >>> 28;
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = -((term * x2) >>> 28) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    amp = (64'sd1 <<< (D_WIDTH - 1)) - 64'sd1;
    mag = (amp * sum + (64'sd1 <<< 27)) >>> 28;
    res = (quad >= 2) ? (64'sd1 <<< (D_WIDTH - 1)) - mag : (64'sd1 <<< (D_WIDTH - 1)) + mag;
    sine_entry = D_WIDTH'(res);
  endfunction

  // Left-justify an address into a sample: zero-fills when narrower, keeps MSBs when wider.
  function automatic logic [D_WIDTH-1:0] scale(input logic [A_WIDTH-1:0] a);
    scale = D_WIDTH'({a, {D_WIDTH{1'b0}}} >> A_WIDTH);
  endfunction

  function automatic logic [D_WIDTH-1:0] wave(input logic [1:0] md,
                                              input logic [A_WIDTH-1:0] a,
                                              input logic [D_WIDTH-1:0] sine);
    logic [A_WIDTH-1:0] t;
    t = {a[A_WIDTH-2:0], 1'b0};
    case (md)
      2'd0:    wave = sine;
      2'd1:    wave = a[A_WIDTH-1] ? {D_WIDTH{1'b0}} : {D_WIDTH{1'b1}};
      2'd2:    wave = scale(a);
      2'd3:    wave = scale(a[A_WIDTH-1] ? ~t : t);
      default: wave = {D_WIDTH{1'b0}};
    endcase
  endfunction

  logic [D_WIDTH-1:0] rom_s [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [D_WIDTH-1:0] SINE_V = sine_entry(g);
    assign rom_s[g] = SINE_V;
  end

  state_t              state_r;
  logic [PHASE_W-1:0]  phase_r;
  logic [BURST_W-1:0]  cnt_r;
  logic [BURST_W-1:0]  len_r;
  logic [BURST_W-1:0]  cnt_nx_s;
  logic                issue_s;
  logic [A_WIDTH-1:0]  addr_s  [N_CH];
  logic                v1_r;
  logic [1:0]          mode1_r;
  logic [A_WIDTH-1:0]  addr1_r [N_CH];
  logic [D_WIDTH-1:0]  rom1_r  [N_CH];

  assign cnt_nx_s = cnt_r + BURST_W'(1);
  // The issued sample uses the phase before this cycle's advance.
  assign issue_s  = (state_r != IDLE) && en;

  // Per-channel table address from the phase MSBs plus the channel offset
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      addr_s[k] = phase_r[PHASE_W-1 -: A_WIDTH] + offset[k*A_WIDTH +: A_WIDTH];
    end
  end

  // Control FSM with phase accumulator, burst counter and registered busy
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      phase_r <= {PHASE_W{1'b0}};
      cnt_r   <= {BURST_W{1'b0}};
      len_r   <= {BURST_W{1'b0}};
      busy    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !stop) begin
            phase_r <= {PHASE_W{1'b0}};
            cnt_r   <= {BURST_W{1'b0}};
            len_r   <= burst_len;
            state_r <= (burst_len != {BURST_W{1'b0}}) ? BURST : RUN;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          if (en) phase_r <= phase_r + incr;
          if (stop) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        BURST: begin
          if (en) begin
            phase_r <= phase_r + incr;
            cnt_r   <= cnt_nx_s;
          end
          if (stop || (en && cnt_nx_s == len_r)) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: ROM read with address, mode and valid carried alongside
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r    <= 1'b0;
      mode1_r <= 2'd0;
      for (int k = 0; k < N_CH; k++) begin
        addr1_r[k] <= {A_WIDTH{1'b0}};
        rom1_r[k]  <= {D_WIDTH{1'b0}};
      end
    end else begin
      v1_r <= issue_s;
      if (issue_s) begin
        mode1_r <= mode;
        for (int k = 0; k < N_CH; k++) begin
          addr1_r[k] <= addr_s[k];
          rom1_r[k]  <= rom_s[addr_s[k]];
        end
      end
    end
  end

  // Stage 2: waveform select; dout holds between valid samples
  always_ff @(posedge clk) begin
    if (rst) begin
      dvalid <= 1'b0;
      dout   <= {(N_CH*D_WIDTH){1'b0}};
    end else begin
      dvalid <= v1_r;
      if (v1_r) begin
        for (int k = 0; k < N_CH; k++) begin
          dout[k*D_WIDTH +: D_WIDTH] <= wave(mode1_r, addr1_r[k], rom1_r[k]);
        end
      end
    end
  end

endmodule

// File: tb/tb_dds_multichan_gen.sv
// Bench for dds_multichan_gen: directed vector table, corner sequences, and random
// stimulus against a cycle-level behavioural model built from the waveform formulas.
module tb_dds_multichan_gen;

  localparam int PW = 16, AW = 8, DW = 8, NC = 2, BW = 16;
  localparam int DEPTH = 1 << AW;
  localparam real PI = 3.14159265358979;

  logic            clk = 1'b0;
  logic            rst = 1'b0, en = 1'b0, start = 1'b0, stop = 1'b0;
  logic [BW-1:0]   burst_len = '0;
  logic [1:0]      mode = '0;
  logic [PW-1:0]   incr = '0;
  logic [NC*AW-1:0] offset = '0;
  logic            busy, dvalid;
  logic [NC*DW-1:0] dout;

  dds_multichan_gen #(.PHASE_W(PW), .A_WIDTH(AW), .D_WIDTH(DW), .N_CH(NC), .BURST_W(BW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .burst_len(burst_len),
    .mode(mode), .incr(incr), .offset(offset), .busy(busy), .dvalid(dvalid), .dout(dout));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, edge_n = 0;

  // Reference model state: 0 idle, 1 free-run, 2 burst
  int m_state = 0, m_phase = 0, m_cnt = 0, m_len = 0;
  typedef struct { int due; logic [NC*DW-1:0] val; } pend_t;
  pend_t pq[$];
  logic [NC*DW-1:0] m_last = '0;
  logic [NC*DW-1:0] seen[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_n, act, exp);
    end
  endtask

  function automatic int wave_ref(input int md, input int a);
    real r;
    int t;
    case (md)
      0: begin
        r = real'((1 << (DW - 1)) - 1) * $sin(2.0 * PI * real'(a) / real'(DEPTH));
        return $rtoi(r + ((r >= 0.0) ? 0.5 : -0.5)) + (1 << (DW - 1));
      end
      1: return (a < DEPTH / 2) ? (1 << DW) - 1 : 0;
      2: return a * (1 << DW) / DEPTH;
      3: begin
        t = (2 * a) % DEPTH;
        if (a >= DEPTH / 2) t = DEPTH - 1 - t;
        return t * (1 << DW) / DEPTH;
      end
      default: return 0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    pend_t p;
    int a;
    if (rst) begin
      m_state = 0; m_phase = 0; m_cnt = 0; m_len = 0;
      pq.delete();
      m_last = '0;
    end else begin
      if (m_state != 0 && en) begin
        p.due = edge_n + 2;
        p.val = '0;
        for (int k = 0; k < NC; k++) begin
          a = ((m_phase >> (PW - AW)) + int'(offset[k*AW +: AW])) % DEPTH;
          p.val[k*DW +: DW] = DW'(wave_ref(int'(mode), a));
        end
        pq.push_back(p);
      end
      if (m_state == 0) begin
        if (start && !stop) begin
          m_phase = 0; m_cnt = 0; m_len = int'(burst_len);
          m_state = (m_len != 0) ? 2 : 1;
        end
      end else begin
        if (en) begin
          m_phase = (m_phase + int'(incr)) % (1 << PW);
          if (m_state == 2) begin
            m_cnt++;
            if (m_cnt == m_len) m_state = 0;
          end
        end
        if (stop) m_state = 0;
      end
    end
  endtask

  task automatic tick();
    logic exp_v;
    model_edge();
    @(posedge clk);
    edge_n++;
    #1;
    exp_v = 1'b0;
    if (pq.size() > 0 && pq[0].due == edge_n) begin
      exp_v  = 1'b1;
      m_last = pq[0].val;
      void'(pq.pop_front());
    end
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("dvalid", 32'(dvalid), 32'(exp_v));
    chk("dout", 32'(dout), 32'(m_last));
    if (dvalid) seen.push_back(dout);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] md; logic [15:0] inc; logic [7:0] o0, o1;
    logic [7:0] e0a, e1a, e0b, e1b;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int first;
    int en_pat[7];
    logic busy_hist[7];

    vecs[0] = '{md: 2'd0, inc: 16'h0100, o0: 8'd0, o1: 8'd64,   e0a: 8'd128, e1a: 8'd255, e0b: 8'd131, e1b: 8'd255};
    vecs[1] = '{md: 2'd1, inc: 16'h8000, o0: 8'd0, o1: 8'd128,  e0a: 8'd255, e1a: 8'd0,   e0b: 8'd0,   e1b: 8'd255};
    vecs[2] = '{md: 2'd2, inc: 16'h0100, o0: 8'd0, o1: 8'hFF,   e0a: 8'd0,   e1a: 8'd255, e0b: 8'd1,   e1b: 8'd0};
    vecs[3] = '{md: 2'd3, inc: 16'h0100, o0: 8'd0, o1: 8'd64,   e0a: 8'd0,   e1a: 8'd128, e0b: 8'd2,   e1b: 8'd130};
    vecs[4] = '{md: 2'd0, inc: 16'h4000, o0: 8'd0, o1: 8'd0,    e0a: 8'd128, e1a: 8'd128, e0b: 8'd255, e1b: 8'd255};

    // Reset held with start asserted, then released
    rst = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0; start = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dvalid", 32'(dvalid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);

    // Directed waveform vectors: first two samples and latency
    foreach (vecs[v]) begin
      do_reset();
      mode = vecs[v].md; incr = vecs[v].inc; offset = {vecs[v].o1, vecs[v].o0};
      burst_len = '0;
      start = 1'b1; tick(); start = 1'b0;
      en = 1'b1; seen.delete(); first = 0;
      for (int i = 1; i <= 10 && seen.size() < 2; i++) begin
        tick();
        if (seen.size() >= 1 && first == 0) first = i;
      end
      chk("vec_latency", 32'(first), 32'd2);
      if (seen.size() >= 2) begin
        chk("vec_ch0_s0", 32'(seen[0][7:0]),  32'(vecs[v].e0a));
        chk("vec_ch1_s0", 32'(seen[0][15:8]), 32'(vecs[v].e1a));
        chk("vec_ch0_s1", 32'(seen[1][7:0]),  32'(vecs[v].e0b));
        chk("vec_ch1_s1", 32'(seen[1][15:8]), 32'(vecs[v].e1b));
      end else begin
        chk("vec_sample_timeout", 32'(seen.size()), 32'd2);
      end
      for (int i = 0; i < 4; i++) tick();
      chk("vec_continuous", 32'(dvalid), 32'd1);
    end

    // Burst of 5 with en gaps; burst_len changed after start must not matter
    do_reset();
    mode = 2'd0; incr = 16'h0100; offset = '0; burst_len = 16'd5;
    start = 1'b1; tick(); start = 1'b0; burst_len = 16'd2;
    seen.delete();
    en_pat = '{1, 0, 1, 1, 0, 1, 1};
    for (int i = 0; i < 7; i++) begin
      en = en_pat[i][0];
      tick();
      busy_hist[i] = busy;
    end
    en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("burst_count", 32'(seen.size()), 32'd5);
    chk("burst_busy_before_last", 32'(busy_hist[5]), 32'd1);
    chk("burst_busy_after_last", 32'(busy_hist[6]), 32'd0);

    // start and stop together from IDLE
    do_reset();
    seen.delete();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("startstop_busy", 32'(busy), 32'd0);
    chk("startstop_dvalid_count", 32'(seen.size()), 32'd0);

    // start during RUN must not reset the phase
    do_reset();
    mode = 2'd2; incr = 16'h0100; offset = '0; burst_len = '0;
    start = 1'b1; tick(); start = 1'b0;
    en = 1'b1; seen.delete();
    for (int i = 0; i < 3; i++) tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    if (seen.size() >= 6) begin
      for (int i = 0; i < 6; i++) chk("run_restart_ignored", 32'(seen[i][7:0]), 32'(i));
    end else begin
      chk("run_restart_timeout", 32'(seen.size()), 32'd6);
    end

    // rst in the middle of a burst drops in-flight samples
    do_reset();
    mode = 2'd1; incr = 16'h1000; burst_len = 16'd10;
    start = 1'b1; tick(); start = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_dvalid", 32'(dvalid), 32'd0);
    seen.delete();
    for (int i = 0; i < 4; i++) tick();
    chk("midrst_no_trailing", 32'(seen.size()), 32'd0);

    // Random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 19) == 0);
      en        = ($urandom_range(0, 3) != 0);
      burst_len = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 9));
      mode      = 2'($urandom_range(0, 3));
      incr      = 16'($urandom);
      offset    = 16'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
